// File: rtl/grf_arb_pkg.sv
// Shared widths, zero-register constant and FIFO entry type for the GRF write-port arbiter.
package grf_arb_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } grf_entry_t;
endpackage

// File: rtl/grf_arb_fifo.sv
// Circular buffer for side-requester results, with per-entry address taps for pending checks.
module grf_arb_fifo
    import grf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  grf_entry_t                  push_entry,
    input  logic                        pop,
    output grf_entry_t                  head,
    output logic [$clog2(DEPTH):0]      count,
    output logic [DEPTH-1:0]            entry_valid,
    output logic [DEPTH-1:0][AW-1:0]    entry_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    grf_entry_t       mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;

    // Pointers wrap naturally because DEPTH is a power of two; valid bits track live entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (push) begin
                entry_valid[wptr] <= 1'b1;
                wptr              <= wptr + 1'b1;
            end
            if (pop) begin
                entry_valid[rptr] <= 1'b0;
                rptr              <= rptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; the valid bits decide what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_entry;
    end

    assign head = mem[rptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_taps
        assign entry_addr[i] = mem[i].addr;
    end
endmodule

// File: rtl/grf_wport_arbiter.sv
// Shares the GRF write port between the W stage (always wins) and buffered mult/div results.
module grf_wport_arbiter
    import grf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_data,
    output logic          grf_we,
    output logic [AW-1:0] grf_addr,
    output logic [DW-1:0] grf_wdata,
    output logic          stall_req,
    input  logic [AW-1:0] q_rs,
    input  logic [AW-1:0] q_rt,
    output logic          pend_rs,
    output logic          pend_rt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    grf_entry_t            head;
    logic [CW-1:0]         count;
    logic [DEPTH-1:0]      entry_valid;
    logic [DEPTH-1:0][AW-1:0] entry_addr;
    logic [SW-1:0]         starve_cnt;
    logic                  w_eff, empty, full, push, pop;

    assign w_eff   = w_we & (w_addr != ZERO_REG);
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // Gated by reset so the requester sees no room while reset is held.
    assign x_ready = reset & ~full;
    // Writes to r0 are accepted but never occupy an entry.
    assign push    = x_valid & x_ready & (x_addr != ZERO_REG);
    assign pop     = ~w_eff & ~empty;

    grf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  ('{addr: x_addr, data: x_data}),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Port mux: W stage first, then FIFO head, else idle; forced idle during reset.
    always_comb begin
        grf_we    = 1'b0;
        grf_addr  = '0;
        grf_wdata = '0;
        if (reset) begin
            if (w_eff) begin
                grf_we    = 1'b1;
                grf_addr  = w_addr;
                grf_wdata = w_data;
            end else if (!empty) begin
                grf_we    = 1'b1;
                grf_addr  = head.addr;
                grf_wdata = head.data;
            end
        end
    end

    // Count consecutive cycles a non-empty FIFO loses the port to the W stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (empty || pop)
            starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign stall_req = full | (~empty & (starve_cnt == SW'(STARVE_LIMIT)));

    // Pending compare against every live buffered entry; r0 is never pending.
    always_comb begin
        pend_rs = 1'b0;
        pend_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_addr[i] == q_rs) pend_rs = 1'b1;
            if (entry_valid[i] && entry_addr[i] == q_rt) pend_rt = 1'b1;
        end
        if (q_rs == ZERO_REG) pend_rs = 1'b0;
        if (q_rt == ZERO_REG) pend_rt = 1'b0;
    end
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed vector bench for the GRF write-port arbiter.
module tb_grf_wport_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        w_we, x_valid, x_ready, grf_we, stall_req, pend_rs, pend_rt;
    logic [4:0]  w_addr, x_addr, grf_addr, q_rs, q_rt;
    logic [31:0] w_data, x_data, grf_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_addr(x_addr), .x_data(x_data),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .stall_req(stall_req),
        .q_rs(q_rs), .q_rt(q_rt), .pend_rs(pend_rs), .pend_rt(pend_rt)
    );

    typedef struct {
        logic        w_we;  logic [4:0] w_addr; logic [31:0] w_data;
        logic        x_valid; logic [4:0] x_addr; logic [31:0] x_data;
        logic [4:0]  q_rs;  logic [4:0] q_rt;
        logic        e_we;  logic [4:0] e_addr; logic [31:0] e_data;
        logic        e_xr;  logic e_st; logic e_prs; logic e_prt;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        w_we = v.w_we; w_addr = v.w_addr; w_data = v.w_data;
        x_valid = v.x_valid; x_addr = v.x_addr; x_data = v.x_data;
        q_rs = v.q_rs; q_rt = v.q_rt;
    endtask

    task automatic check_all(input string tag, input int idx, input vec_t v);
        chk({tag, ".grf_we"},    idx, 32'(grf_we),    32'(v.e_we));
        chk({tag, ".grf_addr"},  idx, 32'(grf_addr),  32'(v.e_addr));
        chk({tag, ".grf_wdata"}, idx, grf_wdata,      v.e_data);
        chk({tag, ".x_ready"},   idx, 32'(x_ready),   32'(v.e_xr));
        chk({tag, ".stall_req"}, idx, 32'(stall_req), 32'(v.e_st));
        chk({tag, ".pend_rs"},   idx, 32'(pend_rs),   32'(v.e_prs));
        chk({tag, ".pend_rt"},   idx, 32'(pend_rt),   32'(v.e_prt));
    endtask

    initial begin
        //            w_we w_a  w_data        xv  x_a  x_data      rs  rt   we  ga  gdata         xr st prs prt
        // side path: accept at edge, write next idle cycle
        vt[0]  = '{0, 0, 32'h0,        0, 0,  32'h0,    0,  0,   0, 0,  32'h0,        1, 0, 0, 0};
        vt[1]  = '{0, 0, 32'h0,        1, 5,  32'h1234, 5,  0,   0, 0,  32'h0,        1, 0, 0, 0};
        vt[2]  = '{0, 0, 32'h0,        0, 0,  32'h0,    5,  0,   1, 5,  32'h1234,     1, 0, 1, 0};
        vt[3]  = '{0, 0, 32'h0,        0, 0,  32'h0,    5,  0,   0, 0,  32'h0,        1, 0, 0, 0};
        // W busy fills the FIFO; one bubble drains head, next idle drains second
        vt[4]  = '{1, 3, 32'hAAAA0003, 1, 7,  32'h77,   0,  0,   1, 3,  32'hAAAA0003, 1, 0, 0, 0};
        vt[5]  = '{1, 3, 32'hAAAA0004, 1, 8,  32'h88,   0,  0,   1, 3,  32'hAAAA0004, 1, 0, 0, 0};
        vt[6]  = '{1, 3, 32'hAAAA0005, 0, 0,  32'h0,    7,  8,   1, 3,  32'hAAAA0005, 0, 1, 1, 1};
        vt[7]  = '{0, 0, 32'h0,        0, 0,  32'h0,    7,  8,   1, 7,  32'h77,       0, 1, 1, 1};
        vt[8]  = '{0, 0, 32'h0,        0, 0,  32'h0,    7,  8,   1, 8,  32'h88,       1, 0, 0, 1};
        vt[9]  = '{0, 0, 32'h0,        0, 0,  32'h0,    7,  8,   0, 0,  32'h0,        1, 0, 0, 0};
        // starvation: one entry blocked by W for 4 cycles raises stall_req
        vt[10] = '{1, 3, 32'h30,       1, 9,  32'h99,   8,  9,   1, 3,  32'h30,       1, 0, 0, 0};
        vt[11] = '{1, 3, 32'h31,       0, 0,  32'h0,    8,  9,   1, 3,  32'h31,       1, 0, 0, 1};
        vt[12] = '{1, 3, 32'h32,       0, 0,  32'h0,    8,  9,   1, 3,  32'h32,       1, 0, 0, 1};
        vt[13] = '{1, 3, 32'h33,       0, 0,  32'h0,    8,  9,   1, 3,  32'h33,       1, 0, 0, 1};
        vt[14] = '{1, 3, 32'h34,       0, 0,  32'h0,    8,  9,   1, 3,  32'h34,       1, 0, 0, 1};
        vt[15] = '{1, 3, 32'h35,       0, 0,  32'h0,    8,  9,   1, 3,  32'h35,       1, 1, 0, 1};
        vt[16] = '{0, 0, 32'h0,        0, 0,  32'h0,    8,  9,   1, 9,  32'h99,       1, 1, 0, 1};
        vt[17] = '{0, 0, 32'h0,        0, 0,  32'h0,    8,  9,   0, 0,  32'h0,        1, 0, 0, 0};
        // r0 on both paths: nothing written, nothing buffered
        vt[18] = '{1, 0, 32'hFFFF,     1, 0,  32'h55,   0,  0,   0, 0,  32'h0,        1, 0, 0, 0};
        vt[19] = '{0, 0, 32'h0,        0, 0,  32'h0,    0,  0,   0, 0,  32'h0,        1, 0, 0, 0};

        // reset state, with W trying to write
        reset = 1'b0;
        drive('{1, 3, 32'hDEAD, 1, 4, 32'h1, 3, 4, 0, 0, 0, 0, 0, 0, 0});
        #2;
        check_all("reset", 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0});
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i]);
            #2;
            check_all("vec", i, vt[i]);
            @(posedge clk);
            #1;
        end

        // reset mid-operation with two buffered entries
        drive('{1, 3, 32'h40, 1, 10, 32'hA0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(posedge clk); #1;
        drive('{1, 3, 32'h41, 1, 11, 32'hB0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(posedge clk); #1;
        drive('{1, 3, 32'h42, 0, 0, 32'h0, 10, 11, 0, 0, 0, 0, 0, 0, 0});
        #1;
        check_all("prerst", 0, '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h42, 0, 1, 1, 1});
        #1 reset = 1'b0;
        #1;
        check_all("midrst", 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0});
        @(posedge clk); #3;
        reset = 1'b1;
        drive('{0, 0, 32'h0, 0, 0, 32'h0, 10, 11, 0, 0, 0, 0, 0, 0, 0});
        for (int i = 0; i < 4; i++) begin
            #1;
            check_all("postrst", i, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0});
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/grf_wport_arbiter.md
# grf_wport_arbiter

Shares the single GRF write port between the W pipeline stage and an out-of-pipeline requester: the multi-cycle mult/div unit returning GPR results. W-stage writes are always granted with no added latency. Side-requester results are buffered in a small FIFO and drained into idle write-port cycles. A starvation counter and a full condition raise a stall request toward the hazard unit. The block sits between the W stage outputs (grf_write, grf_dst-resolved address, grf_data_in) and the GRF write port.

## Interface
- DEPTH, 2, side-request FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may be blocked by W writes before stall_req asserts
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- w_we  in  1  W-stage write enable
- w_addr  in  5  W-stage destination register
- w_data  in  32  W-stage write data
- x_valid  in  1  side requester has a result
- x_ready  out  1  arbiter can accept a side result
- x_addr  in  5  side destination register
- x_data  in  32  side result data
- grf_we  out  1  GRF write enable
- grf_addr  out  5  GRF write address
- grf_wdata  out  32  GRF write data
- stall_req  out  1  request that the hazard unit insert a W-stage bubble
- q_rs, q_rt  in  5 each  D-stage source registers to check
- pend_rs, pend_rt  out  1 each  queried register has a buffered, unwritten side result

## Operation
- W write is effective when w_we=1 and w_addr≠0; it always owns the port that cycle.
- A side request is accepted on a rising edge with x_valid&x_ready. If x_addr=0, it is accepted and discarded, with no FIFO entry.
- x_ready = (count<DEPTH). There is no same-cycle pop-to-push bypass.
- Port mux:
  - W effective: grf_*={1,w_addr,w_data}.
  - Else FIFO non-empty: grf_*={1,head.addr,head.data}, and head pops at the edge.
  - Else: grf_we=0, grf_addr=0, grf_wdata=0.
- Push and pop in the same cycle: count is unchanged and pointers advance mod DEPTH.
- starve_cnt:
  - Clears when the FIFO is empty or a pop occurs.
  - Otherwise increments, saturating at STARVE_LIMIT, on each cycle an effective W write blocks a non-empty FIFO.
- stall_req = (count==DEPTH) | (count≠0 & starve_cnt==STARVE_LIMIT). It is combinational from registered state only.
- pend_rs = (q_rs≠0) & any valid entry with addr==q_rs. pend_rt is computed the same way.
- WAW ordering between a W write and a buffered entry to the same register is not checked here. The hazard unit prevents it via pend_*. If it happens anyway, the buffered entry is written later and overwrites.
- No state machine beyond the FIFO and the counter.

## Timing
- W path: zero latency, combinational from w_* to grf_*.
- Side path: minimum latency of 1 cycle (accepted at edge N, written in cycle N+1 if the port is idle).
- The pipeline honours stall_req one cycle later (w_we=0 in the next cycle). The arbiter never drops a W write.
- Reset (asynchronous, while reset=0):
  - count=0, pointers=0, starve_cnt=0, FIFO contents invalidated.
  - grf_we=0, x_ready=0, stall_req=0, pend_*=0.
  - grf_addr=0, grf_wdata=0.
- Reset asserted mid-operation discards buffered results. The side requester is reset by the same signal.
- After reset deasserts: x_ready=1 from the first cycle.

## Structure
- Shared package grf_arb_pkg: GPR address width (5), data width (32), the zero-register constant, and the FIFO entry struct {addr, data}.
- One natural sub-module: grf_arb_fifo. It holds the DEPTH-entry circular buffer with push/pop, count, and per-entry addr outputs for the pending compare.
- The top level holds the mux, starve counter, stall and pending logic.

## Test plan
- Idle W, x_valid=1 with addr=5, data=0x1234 at edge 1 → cycle 2: grf_we=1, grf_addr=5, grf_wdata=0x1234; count returns to 0.
- W writing continuously (addr=3), two side results pushed → count=2, x_ready=0, stall_req=1 in the same cycle. The bench drops w_we for one cycle → head (first pushed) written, then the second written in the next idle cycle.
- One side result buffered, W busy → starve_cnt reaches 4, stall_req=1. The first W bubble pops the entry and stall_req deasserts the next cycle.
- x_addr=0 and w_addr=0 with w_we=1 → grf_we=0 and the FIFO stays empty. q_rs=0 → pend_rs=0.
- Entry addr=9 buffered, q_rt=9 → pend_rt=1 until the cycle after it is written. q_rs=8 → pend_rs=0.
- reset pulled low with two entries buffered → immediately grf_we=0, x_ready=0, pend_*=0. After release, no stale write ever appears.
